// File: rtl/fdd_motor_ctrl.sv
// Drive-side spindle model for two floppy units.
// Turns per-drive motor requests into a spun-up flag after a spin-up delay. Keeps each motor
// running for a hold time after its request drops. Produces the index pulse of the selected unit.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   motor_req  per-drive motor request (1 = on)
//   disk_in    per-drive medium present
//   USEL       unit whose index pulse drives INDEXn
//   motor_run  per-drive spun-up flag (RUN or HOLD)
//   spinning   per-drive spindle turning (SPINUP, RUN or HOLD)
//   INDEXn     active-low index pulse of the selected unit
module fdd_motor_ctrl #(
  parameter int unsigned TICK_DIV  = 21477,
  parameter int unsigned SPINUP_MS = 500,
  parameter int unsigned HOLD_MS   = 2000,
  parameter int unsigned ROT_MS    = 200,
  parameter int unsigned INDEX_MS  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] motor_req,
  input  logic [1:0] disk_in,
  input  logic       USEL,
  output logic [1:0] motor_run,
  output logic [1:0] spinning,
  output logic       INDEXn
);

  localparam int unsigned PreW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CntMax = (SPINUP_MS > HOLD_MS) ? SPINUP_MS : HOLD_MS;
  localparam int unsigned CntW  = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam int unsigned RotW  = (ROT_MS > 1) ? $clog2(ROT_MS) : 1;

  localparam logic [PreW-1:0] PreLast    = PreW'(TICK_DIV - 1);
  localparam logic [CntW-1:0] SpinupLast = CntW'(SPINUP_MS - 1);
  localparam logic [CntW-1:0] HoldLast   = CntW'(HOLD_MS - 1);
  localparam logic [RotW-1:0] RotLast    = RotW'(ROT_MS - 1);
  localparam logic [RotW-1:0] IndexLen   = RotW'(INDEX_MS);

  typedef enum logic [1:0] {StOff, StSpinup, StRun, StHold} state_e;

  logic [PreW-1:0] pre_q;
  logic            tick;
  state_e          state_q [2];
  logic [CntW-1:0] cnt_q   [2];
  logic [RotW-1:0] rot_q   [2];

  // 1 ms timebase shared by both drives.
  assign tick = (pre_q == PreLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // Per-drive spindle FSM with its ms timer and rotation counter.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        state_q[i] <= StOff;
        cnt_q[i]   <= '0;
        rot_q[i]   <= '0;
      end else begin
        // Rotation advances while the spindle turns; OFF pins it at 0 below.
        if (tick && state_q[i] != StOff) begin
          rot_q[i] <= (rot_q[i] == RotLast) ? '0 : rot_q[i] + 1'b1;
        end
        unique case (state_q[i])
          StOff: begin
            rot_q[i] <= '0;
            if (motor_req[i]) begin
              state_q[i] <= StSpinup;
              cnt_q[i]   <= '0;
            end
          end
          StSpinup: begin
            // Request level is checked first so a drop on the completing tick aborts.
            if (!motor_req[i]) begin
              state_q[i] <= StOff;
              rot_q[i]   <= '0;
            end else if (tick) begin
              if (cnt_q[i] == SpinupLast) begin
                state_q[i] <= StRun;
              end else begin
                cnt_q[i] <= cnt_q[i] + 1'b1;
              end
            end
          end
          StRun: begin
            if (!motor_req[i]) begin
              state_q[i] <= StHold;
              cnt_q[i]   <= '0;
            end
          end
          StHold: begin
            // Re-request wins over a same-cycle hold expiry.
            if (motor_req[i]) begin
              state_q[i] <= StRun;
            end else if (tick) begin
              if (cnt_q[i] == HoldLast) begin
                state_q[i] <= StOff;
                rot_q[i]   <= '0;
              end else begin
                cnt_q[i] <= cnt_q[i] + 1'b1;
              end
            end
          end
          default: state_q[i] <= StOff;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      motor_run[i] = (state_q[i] == StRun) || (state_q[i] == StHold);
      spinning[i]  = (state_q[i] != StOff);
    end
  end

  // Selection and medium are combinational so a USEL switch changes the source at once.
  assign INDEXn = !(spinning[USEL] && disk_in[USEL] && (rot_q[USEL] < IndexLen));

endmodule

// File: tb/tb_fdd_motor_ctrl.sv
// Directed bench for fdd_motor_ctrl with a shortened timebase
// (TICK_DIV=4, SPINUP_MS=3, HOLD_MS=5, ROT_MS=10, INDEX_MS=2).
// Edge numbers in comments count from the reset edge (E0); a tick is taken on every 4th edge.
module tb_fdd_motor_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] motor_req;
  logic [1:0] disk_in;
  logic       usel;
  logic [1:0] motor_run;
  logic [1:0] spinning;
  logic       indexn;

  int checks = 0;
  int errors = 0;

  fdd_motor_ctrl #(
    .TICK_DIV (4),
    .SPINUP_MS(3),
    .HOLD_MS  (5),
    .ROT_MS   (10),
    .INDEX_MS (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .motor_req(motor_req),
    .disk_in  (disk_in),
    .USEL     (usel),
    .motor_run(motor_run),
    .spinning (spinning),
    .INDEXn   (indexn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [1:0] disk;
    logic       sel;
    int         n;      // edges to advance before checking
    logic [1:0] run;
    logic [1:0] spin;
    logic       idx;
    string      name;
  } vec_t;

  vec_t vecs [20];

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string name, input logic [1:0] run, input logic [1:0] spin,
                           input logic idx);
    check({name, ".motor_run"}, motor_run, run);
    check({name, ".spinning"}, spinning, spin);
    check({name, ".INDEXn"}, {1'b0, indexn}, {1'b0, idx});
  endtask

  task automatic step(input logic [1:0] req, input logic [1:0] disk, input logic sel,
                      input int n, input logic [1:0] run, input logic [1:0] spin,
                      input logic idx, input string name);
    motor_req = req;
    disk_in   = disk;
    usel      = sel;
    repeat (n) @(posedge clk);
    #1;
    check_all(name, run, spin, idx);
  endtask

  // Holds reset for two edges, checks the reset state, then releases with req=00.
  task automatic do_reset(input string name);
    reset     = 1'b1;
    motor_req = 2'b01;
    disk_in   = 2'b01;
    usel      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all(name, 2'b00, 2'b00, 1'b1);
    reset     = 1'b0;
    motor_req = 2'b00;
  endtask

  initial begin
    reset     = 1'b1;
    motor_req = 2'b00;
    disk_in   = 2'b00;
    usel      = 1'b0;

    //             req    disk   sel   n   run    spin   idx
    vecs[0]  = '{2'b01, 2'b01, 1'b0, 1,  2'b00, 2'b01, 1'b0, "spinup_start"};   // E1 rot0
    vecs[1]  = '{2'b01, 2'b01, 1'b0, 10, 2'b00, 2'b01, 1'b1, "spinup_before"};  // E11 rot2
    vecs[2]  = '{2'b01, 2'b01, 1'b0, 1,  2'b01, 2'b01, 1'b1, "spinup_done"};    // E12 3rd tick
    vecs[3]  = '{2'b01, 2'b01, 1'b0, 27, 2'b01, 2'b01, 1'b1, "rot9"};           // E39
    vecs[4]  = '{2'b01, 2'b01, 1'b0, 1,  2'b01, 2'b01, 1'b0, "index_fall"};     // E40 rot0
    vecs[5]  = '{2'b01, 2'b01, 1'b0, 7,  2'b01, 2'b01, 1'b0, "index_end"};      // E47 rot1
    vecs[6]  = '{2'b01, 2'b01, 1'b0, 1,  2'b01, 2'b01, 1'b1, "index_rise"};     // E48 rot2
    vecs[7]  = '{2'b01, 2'b00, 1'b0, 32, 2'b01, 2'b01, 1'b1, "no_disk"};        // E80 rot0
    vecs[8]  = '{2'b01, 2'b01, 1'b0, 1,  2'b01, 2'b01, 1'b0, "disk_back"};      // E81 rot0
    vecs[9]  = '{2'b01, 2'b11, 1'b1, 1,  2'b01, 2'b01, 1'b1, "usel1_off"};      // E82
    vecs[10] = '{2'b11, 2'b11, 1'b1, 1,  2'b01, 2'b11, 1'b0, "d1_spin_idx"};    // E83 d1 rot0
    vecs[11] = '{2'b11, 2'b01, 1'b0, 8,  2'b01, 2'b11, 1'b1, "d1_spinup"};      // E91
    vecs[12] = '{2'b11, 2'b01, 1'b0, 1,  2'b11, 2'b11, 1'b1, "d1_run"};         // E92
    vecs[13] = '{2'b01, 2'b01, 1'b0, 2,  2'b11, 2'b11, 1'b1, "d1_hold"};        // E94
    vecs[14] = '{2'b01, 2'b01, 1'b0, 17, 2'b11, 2'b11, 1'b1, "d1_hold_last"};   // E111
    vecs[15] = '{2'b01, 2'b01, 1'b0, 1,  2'b01, 2'b01, 1'b1, "d1_off_d0_run"};  // E112
    vecs[16] = '{2'b00, 2'b01, 1'b0, 1,  2'b01, 2'b01, 1'b1, "d0_hold"};        // E113
    vecs[17] = '{2'b00, 2'b01, 1'b0, 18, 2'b01, 2'b01, 1'b1, "d0_hold_tick4"};  // E131
    vecs[18] = '{2'b01, 2'b01, 1'b0, 1,  2'b01, 2'b01, 1'b1, "d0_rereq_exp"};   // E132
    vecs[19] = '{2'b01, 2'b01, 1'b0, 4,  2'b01, 2'b01, 1'b1, "d0_still_run"};   // E136

    do_reset("reset_a");
    for (int i = 0; i < 20; i++) begin
      step(vecs[i].req, vecs[i].disk, vecs[i].sel, vecs[i].n,
           vecs[i].run, vecs[i].spin, vecs[i].idx, vecs[i].name);
    end

    // Abort during spin-up.
    do_reset("reset_b");
    step(2'b01, 2'b01, 1'b0, 1,  2'b00, 2'b01, 1'b0, "abort_spin");
    step(2'b00, 2'b01, 1'b0, 1,  2'b00, 2'b00, 1'b1, "abort_off");
    step(2'b00, 2'b01, 1'b0, 20, 2'b00, 2'b00, 1'b1, "abort_stay");

    // Request dropped on the exact completing tick (E12).
    do_reset("reset_c");
    step(2'b01, 2'b01, 1'b0, 11, 2'b00, 2'b01, 1'b1, "prio_pre");
    step(2'b00, 2'b01, 1'b0, 1,  2'b00, 2'b00, 1'b1, "prio_off");
    step(2'b00, 2'b01, 1'b0, 4,  2'b00, 2'b00, 1'b1, "prio_never_run");

    // Reset in the middle of HOLD, then a full spin-up again.
    do_reset("reset_d");
    step(2'b01, 2'b01, 1'b0, 12, 2'b01, 2'b01, 1'b1, "d_run");
    step(2'b00, 2'b01, 1'b0, 4,  2'b01, 2'b01, 1'b1, "d_hold");
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all("reset_mid_hold", 2'b00, 2'b00, 1'b1);
    reset = 1'b0;
    step(2'b01, 2'b01, 1'b0, 11, 2'b00, 2'b01, 1'b1, "restart_spinup");
    step(2'b01, 2'b01, 1'b0, 1,  2'b01, 2'b01, 1'b1, "restart_run");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
